// File: rtl/cnn_pkg.sv
// Shared constants, state encoding and helpers for the CNN line-buffer front end.
package cnn_pkg;

  localparam int unsigned ROW_W   = 100;
  localparam int unsigned IMG_H   = 100;
  localparam int unsigned PIX_W   = 8;
  localparam int unsigned NUM_BUF = 3;

  // Line-buffer control states
  typedef enum logic [1:0] {
    FILL   = 2'd0,
    VALID  = 2'd1,
    REFILL = 2'd2
  } lb_state_e;

  // Advance a row-buffer index modulo three
  function automatic logic [1:0] next_buf(input logic [1:0] b);
    return (b == 2'd2) ? 2'd0 : b + 2'd1;
  endfunction

endpackage

// File: rtl/lb_row_ram.sv
// One image row of pixel storage with a registered three-pixel window read.
module lb_row_ram #(
  parameter int unsigned ROW_W = 100,
  parameter int unsigned PIX_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(ROW_W)-1:0] waddr,
  input  logic [PIX_W-1:0]         wdata,
  input  logic [$clog2(ROW_W)-1:0] raddr,
  output logic [3*PIX_W-1:0]       win
);

  localparam int unsigned AW = $clog2(ROW_W);
  localparam int unsigned CW = AW + 1;

  logic [PIX_W-1:0]   mem [ROW_W];
  logic [3*PIX_W-1:0] win_c;
  logic [CW-1:0]      cidx;

  // Pixel write port; contents are deliberately kept across reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Gather columns raddr..raddr+2, zeroing any byte that falls past the row end
  always_comb begin
    win_c = '0;
    cidx  = '0;
    for (int unsigned j = 0; j < 3; j++) begin
      cidx = CW'(raddr) + CW'(j);
      if (cidx < CW'(ROW_W)) begin
        win_c[(2-j)*PIX_W +: PIX_W] = mem[cidx[AW-1:0]];
      end
    end
  end

  // Window output register, reloaded every cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      win <= '0;
    end else begin
      win <= win_c;
    end
  end

endmodule

// File: rtl/line_buffer_fill.sv
// Three-row circular line buffer that feeds 3-pixel windows to a convolution stage.
module line_buffer_fill
  import cnn_pkg::lb_state_e;
  import cnn_pkg::FILL;
  import cnn_pkg::VALID;
  import cnn_pkg::REFILL;
  import cnn_pkg::NUM_BUF;
  import cnn_pkg::next_buf;
#(
  parameter int unsigned ROW_W = cnn_pkg::ROW_W,
  parameter int unsigned IMG_H = cnn_pkg::IMG_H,
  parameter int unsigned PIX_W = cnn_pkg::PIX_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PIX_W-1:0]         pix_in,
  input  logic                     pix_valid,
  output logic                     in_ready,
  input  logic                     rd_en,
  input  logic [$clog2(ROW_W)-1:0] rd_addr,
  output logic [3*PIX_W-1:0]       LB1,
  output logic [3*PIX_W-1:0]       LB2,
  output logic [3*PIX_W-1:0]       LB3,
  output logic                     data_valid,
  output logic [1:0]               k,
  output logic                     frame_done
);

  localparam int unsigned AW = $clog2(ROW_W);
  localparam int unsigned RW = $clog2(IMG_H);

  lb_state_e          state;
  logic [AW-1:0]      col;
  logic [AW-1:0]      rd_cnt;
  logic [RW-1:0]      row_cnt;
  logic [1:0]         fill_buf;
  logic               accept;
  logic               last_col;
  logic [1:0]         wr_buf;
  logic [3*PIX_W-1:0] win [NUM_BUF];

  // Upstream handshake: pixels are taken only while a row is being loaded
  assign in_ready = (state != VALID);
  assign accept   = pix_valid && in_ready;
  assign last_col = (col == AW'(ROW_W - 1));

  // Initial fill walks buffers 0..2; refill always targets the oldest row k
  assign wr_buf = (state == REFILL) ? k : fill_buf;

  // Row storage, one RAM per buffered line
  for (genvar i = 0; i < NUM_BUF; i++) begin : g_row
    lb_row_ram #(
      .ROW_W (ROW_W),
      .PIX_W (PIX_W)
    ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (accept && (wr_buf == 2'(i))),
      .waddr (col),
      .wdata (pix_in),
      .raddr (rd_addr),
      .win   (win[i])
    );
  end

  assign LB1 = win[0];
  assign LB2 = win[1];
  assign LB3 = win[2];

  // Fill / window-read / refill sequencing with registered status outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= FILL;
      col        <= '0;
      rd_cnt     <= '0;
      row_cnt    <= '0;
      fill_buf   <= '0;
      k          <= '0;
      data_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        FILL: begin
          if (accept) begin
            if (last_col) begin
              col <= '0;
              if (fill_buf == 2'd2) begin
                fill_buf   <= '0;
                k          <= '0;
                state      <= VALID;
                data_valid <= 1'b1;
              end else begin
                fill_buf <= fill_buf + 2'd1;
              end
            end else begin
              col <= col + AW'(1);
            end
          end
        end

        VALID: begin
          if (rd_en) begin
            if (rd_cnt == AW'(ROW_W - 3)) begin
              rd_cnt     <= '0;
              data_valid <= 1'b0;
              if (row_cnt == RW'(IMG_H - 3)) begin
                state      <= FILL;
                row_cnt    <= '0;
                k          <= '0;
                frame_done <= 1'b1;
              end else begin
                state   <= REFILL;
                row_cnt <= row_cnt + RW'(1);
              end
            end else begin
              rd_cnt <= rd_cnt + AW'(1);
            end
          end
        end

        REFILL: begin
          if (accept) begin
            if (last_col) begin
              col        <= '0;
              k          <= next_buf(k);
              state      <= VALID;
              data_valid <= 1'b1;
            end else begin
              col <= col + AW'(1);
            end
          end
        end

        default: begin
          state <= FILL;
        end
      endcase
    end
  end

endmodule

// File: doc/line_buffer_fill.md
LINE_BUFFER_FILL -- requirements
Module: line_buffer_fill

Interface
REQ-001 Parameters SHALL be ROW_W, default 100, pixels per image row; IMG_H, default 100, rows per frame; PIX_W, default 8, pixel width.
REQ-002 clk  in  1  sole clock; all logic SHALL update on its rising edge.
REQ-003 rst  in  1  reset; synchronous, active-low.
REQ-004 pix_in  in  8  raster-order input pixel.
REQ-005 pix_valid  in  1  pix_in valid this cycle.
REQ-006 in_ready  out  1  block accepts a pixel this cycle; transfer occurs when pix_valid and in_ready are both high.
REQ-007 rd_en  in  1  window-read strobe from the convolution stage.
REQ-008 rd_addr  in  7  window start column, 0..ROW_W-3.
REQ-009 LB1, LB2, LB3  out  24 each  window from row buffers 0, 1 and 2: [23:16]=col rd_addr, [15:8]=rd_addr+1, [7:0]=rd_addr+2.
REQ-010 data_valid  out  1  three complete rows held; window reads legal.
REQ-011 k  out  2  index of the buffer holding the oldest (top) row: 0, 1 or 2.
REQ-012 frame_done  out  1  one-cycle pulse after the last window row of a frame is released.

Function
REQ-013 States SHALL be FILL, VALID and REFILL.
REQ-014 in_ready SHALL be combinationally high in FILL and REFILL and low in VALID.
REQ-015 FILL: accepted pixels SHALL be written to buffer 0, then 1, then 2, column 0..ROW_W-1 each; after the 3*ROW_W-th pixel: k<=0, state<=VALID.
REQ-016 VALID: data_valid SHALL be 1 (registered, asserted the cycle after entry); each cycle with rd_en=1 SHALL increment a read counter.
REQ-017 On the cycle rd_en=1 with read counter = ROW_W-3 (98th read), the block SHALL clear the counter, deassert data_valid next cycle, and leave VALID.
REQ-018 Leaving VALID: if window-row counter = IMG_H-3, go to FILL, window-row counter<=0, k<=0, frame_done pulses one cycle; else go to REFILL, window-row counter increments.
REQ-019 REFILL: ROW_W accepted pixels SHALL overwrite buffer k, columns 0..ROW_W-1; on the last pixel, k<=(k+1) mod 3 and state<=VALID.
REQ-020 LB1..LB3 SHALL be registered, reloaded every cycle from the current rd_addr regardless of rd_en or state (1-cycle read latency).
REQ-021 rd_addr > ROW_W-3 SHALL yield 0 for every out-of-row byte; in-range bytes are unaffected.
REQ-022 rd_en outside VALID SHALL be ignored; pixels offered while in_ready=0 SHALL not be written; the upstream stage holds them.
REQ-023 Column and buffer pointers SHALL wrap to 0 at ROW_W-1 and 2 respectively; none exceed range.
REQ-024 data_valid SHALL be low in every cycle in which any buffer is being written.

Reset
REQ-025 With rst=0 at a clock edge: state<=FILL; all counters and pointers <=0; k<=0; data_valid, frame_done<=0; LB1..LB3<=0.
REQ-026 Buffer contents SHALL not be cleared; reset mid-frame discards partial rows, and the next accepted pixel is column 0 of buffer 0.

Structure
REQ-027 A shared package cnn_pkg SHALL hold ROW_W, IMG_H, PIX_W and the FILL/VALID/REFILL state encoding.
REQ-028 One sub-module lb_row_ram (ROW_W x PIX_W, one write port, registered 3-byte window read) SHALL be instantiated three times.

Verification
REQ-029 Stream 300 pixels of value (col mod 256) -> data_valid=1 the cycle after the 300th; rd_addr=5 -> LB1=LB2=LB3=0x050607 next cycle.
REQ-030 In VALID, 97 rd_en pulses -> data_valid stays 1; 98th pulse -> data_valid=0 next cycle, in_ready=1, k unchanged until refill.
REQ-031 Refill 100 pixels of value 0xAA -> k=1, data_valid=1; rd_addr=0 -> LB1=0xAAAAAA.
REQ-032 Run a full 100x100 frame -> exactly 98 VALID periods, k sequence 0,1,2,0,...; frame_done pulses once; state returns to FILL with k=0.
REQ-033 rd_addr=99 -> LB outputs have [15:0]=0; pixels offered with pix_valid=1 during VALID are not written; rd_en in FILL does not alter the counter.
REQ-034 rst=0 after 150 FILL pixels -> outputs zero; 300 new pixels -> data_valid=1 with only new data in LB1..LB3.
